// File: rtl/wide_cmp_pkg.sv
// Shared definitions for the sequential wide-word comparator.
// Holds the controller state encoding and the digit width.
package wide_cmp_pkg;

   localparam int NIBBLE_W = 4;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_SCAN = 1'b1
   } state_t;

endpackage

// File: rtl/wide_cmp_seq_comparator.sv
// Combinational 4-bit magnitude comparator.
// Exactly one of equal/bigger/less is high for any input pair.
module comparator (
   input  logic [3:0] A,
   input  logic [3:0] B,
   output logic       equal,
   output logic       bigger,
   output logic       less
);

   logic [3:0] bit_eq;

   always_comb begin
      bit_eq = ~(A ^ B);
      equal  = &bit_eq;
      // MSB-first priority: a bit decides only if every higher bit matched
      bigger = (A[3] & ~B[3])
             | (bit_eq[3] & A[2] & ~B[2])
             | (&bit_eq[3:2] & A[1] & ~B[1])
             | (&bit_eq[3:1] & A[0] & ~B[0]);
      less   = ~equal & ~bigger;
   end

endmodule

// File: rtl/wide_cmp_seq.sv
// Sequential wide magnitude comparator: scans one nibble per cycle, MSB first,
// through a single 4-bit comparator and stops at the first differing nibble.
module wide_cmp_seq
   import wide_cmp_pkg::*;
#(
   parameter int NIBBLES = 4,
   parameter int CW      = $clog2(NIBBLES + 1)
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         start,
   input  logic [NIBBLE_W*NIBBLES-1:0]  a,
   input  logic [NIBBLE_W*NIBBLES-1:0]  b,
   output logic                         busy,
   output logic                         done,
   output logic                         equal,
   output logic                         bigger,
   output logic                         less,
   output logic [CW-1:0]                nib_used
);

   localparam int W  = NIBBLE_W * NIBBLES;
   localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
   localparam logic [IW-1:0] IDX_TOP = IW'(NIBBLES - 1);
   localparam logic [CW-1:0] NIB_CNT = CW'(NIBBLES);

   state_t          state_q, state_d;
   logic [IW-1:0]   idx_q, idx_d;
   logic [W-1:0]    op_a_q, op_a_d;
   logic [W-1:0]    op_b_q, op_b_d;
   logic            done_q, done_d;
   logic            eq_q, eq_d;
   logic            bg_q, bg_d;
   logic            ls_q, ls_d;
   logic [CW-1:0]   nu_q, nu_d;

   logic [NIBBLE_W-1:0] nib_a, nib_b;
   logic                c_eq, c_bg, c_ls;

   always_comb begin
      nib_a = op_a_q[idx_q * NIBBLE_W +: NIBBLE_W];
      nib_b = op_b_q[idx_q * NIBBLE_W +: NIBBLE_W];
   end

   comparator u_cmp (
      .A      (nib_a),
      .B      (nib_b),
      .equal  (c_eq),
      .bigger (c_bg),
      .less   (c_ls)
   );

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      op_a_d  = op_a_q;
      op_b_d  = op_b_q;
      done_d  = 1'b0;
      eq_d    = eq_q;
      bg_d    = bg_q;
      ls_d    = ls_q;
      nu_d    = nu_q;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               op_a_d  = a;
               op_b_d  = b;
               idx_d   = IDX_TOP;
               state_d = ST_SCAN;
            end
         end
         ST_SCAN: begin
            if (!c_eq) begin
               state_d = ST_IDLE;
               done_d  = 1'b1;
               eq_d    = 1'b0;
               bg_d    = c_bg;
               ls_d    = c_ls;
               nu_d    = NIB_CNT - CW'(idx_q);
            end else if (idx_q == '0) begin
               state_d = ST_IDLE;
               done_d  = 1'b1;
               eq_d    = 1'b1;
               bg_d    = 1'b0;
               ls_d    = 1'b0;
               nu_d    = NIB_CNT;
            end else begin
               idx_d   = idx_q - IW'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
         op_a_q  <= '0;
         op_b_q  <= '0;
         done_q  <= 1'b0;
         eq_q    <= 1'b0;
         bg_q    <= 1'b0;
         ls_q    <= 1'b0;
         nu_q    <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         op_a_q  <= op_a_d;
         op_b_q  <= op_b_d;
         done_q  <= done_d;
         eq_q    <= eq_d;
         bg_q    <= bg_d;
         ls_q    <= ls_d;
         nu_q    <= nu_d;
      end
   end

   always_comb begin
      busy     = (state_q == ST_SCAN);
      done     = done_q;
      equal    = eq_q;
      bigger   = bg_q;
      less     = ls_q;
      nib_used = nu_q;
   end

endmodule

// File: tb/tb_wide_cmp_seq.sv
// Bench for wide_cmp_seq: arithmetic reference model checked every cycle,
// plus directed vectors with literal expectations.
module tb_wide_cmp_seq;

   localparam int NIBBLES = 4;
   localparam int W       = 4 * NIBBLES;
   localparam int CW      = $clog2(NIBBLES + 1);

   logic          clk = 1'b0;
   logic          rst, start;
   logic [W-1:0]  a, b;
   logic          busy, done, equal, bigger, less;
   logic [CW-1:0] nib_used;

   int vectors     = 0;
   int miscompares = 0;
   bit chk_en      = 1'b0;

   always #5 clk = ~clk;

   wide_cmp_seq #(.NIBBLES(NIBBLES)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .a        (a),
      .b        (b),
      .busy     (busy),
      .done     (done),
      .equal    (equal),
      .bigger   (bigger),
      .less     (less),
      .nib_used (nib_used)
   );

   // Reference model: remaining cycles of the current compare plus result flags.
   int            m_left = 0;
   logic          m_done = 1'b0, m_eq = 1'b0, m_bg = 1'b0, m_ls = 1'b0;
   logic [CW-1:0] m_nu = '0;
   logic          p_eq, p_bg, p_ls;
   logic [CW-1:0] p_nu;

   always @(posedge clk) begin
      m_done = 1'b0;
      if (rst) begin
         m_left = 0;
         m_eq = 1'b0; m_bg = 1'b0; m_ls = 1'b0; m_nu = '0;
      end else if (m_left > 0) begin
         m_left = m_left - 1;
         if (m_left == 0) begin
            m_done = 1'b1;
            m_eq = p_eq; m_bg = p_bg; m_ls = p_ls; m_nu = p_nu;
         end
      end else if (start) begin
         int  k;
         bit  found;
         k = NIBBLES;
         found = 1'b0;
         for (int i = 0; i < NIBBLES; i++) begin
            logic [W-1:0] sa, sb;
            sa = a >> (4 * (NIBBLES - 1 - i));
            sb = b >> (4 * (NIBBLES - 1 - i));
            if (!found && (sa[3:0] != sb[3:0])) begin
               k = i + 1;
               found = 1'b1;
            end
         end
         p_eq = (a == b);
         p_bg = (a > b);
         p_ls = (a < b);
         p_nu = CW'(k);
         m_left = k;
      end
   end

   logic prev_done = 1'b0;
   always @(negedge clk) begin
      if (chk_en) begin
         vectors++;
         if ({busy, done, equal, bigger, less, nib_used} !==
             {(m_left > 0), m_done, m_eq, m_bg, m_ls, m_nu}) begin
            miscompares++;
            $display("FAIL cycle_model t=%0t dut busy/done/eq/bg/ls/nu=%b/%b/%b/%b/%b/%0d expected %b/%b/%b/%b/%b/%0d",
                     $time, busy, done, equal, bigger, less, nib_used,
                     (m_left > 0), m_done, m_eq, m_bg, m_ls, m_nu);
         end
         if (done && prev_done) begin
            miscompares++;
            $display("FAIL done_pulse t=%0t done high two cycles in a row, required single pulse", $time);
         end
         prev_done = done;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic issue(input logic [W-1:0] va, input logic [W-1:0] vb);
      a = va; b = vb; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(input string name, input int lat0, output int lat);
      lat = lat0;
      while (done !== 1'b1 && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      if (done !== 1'b1) begin
         miscompares++;
         $display("FAIL %s_timeout no done within %0d cycles, required done", name, lat);
      end
   endtask

   task automatic chk_result(input string name, input int lat, input int exp_lat,
                             input logic e, input logic g, input logic l, input int nu);
      chk({name, "_latency"}, lat, exp_lat);
      chk({name, "_flags"}, {equal, bigger, less}, {e, g, l});
      chk({name, "_nib_used"}, nib_used, nu);
   endtask

   initial begin
      int lat, n;
      rst = 1'b1; start = 1'b0; a = '0; b = '0;
      repeat (2) @(negedge clk);
      chk("reset_outputs", {busy, done, equal, bigger, less, nib_used}, '0);
      chk_en = 1'b1;
      rst = 1'b0;
      @(negedge clk);

      // MSB nibble differs
      issue(16'h9000, 16'h1FFF);
      chk("msb_busy", busy, 1);
      wait_done("msb", 0, lat);
      chk_result("msb", lat, 1, 1'b0, 1'b1, 1'b0, 1);
      chk("model_msb_nu", m_nu, 1);
      @(negedge clk);
      chk("msb_after", {done, busy}, 2'b00);

      // LSB nibble differs
      issue(16'h1234, 16'h1235);
      wait_done("lsb", 0, lat);
      chk_result("lsb", lat, 4, 1'b0, 1'b0, 1'b1, 4);
      chk("model_lsb_ls", m_ls, 1);
      @(negedge clk);

      // Equal operands
      issue(16'hABCD, 16'hABCD);
      wait_done("eq_abcd", 0, lat);
      chk_result("eq_abcd", lat, 4, 1'b1, 1'b0, 1'b0, 4);
      @(negedge clk);
      issue(16'h0000, 16'h0000);
      wait_done("eq_zero", 0, lat);
      chk_result("eq_zero", lat, 4, 1'b1, 1'b0, 1'b0, 4);
      @(negedge clk);

      // Start and operand changes while busy are ignored
      issue(16'h0F00, 16'h0E00);
      a = 16'hFFFF; b = 16'h0000; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done("stable", 1, lat);
      chk_result("stable", lat, 2, 1'b0, 1'b1, 1'b0, 2);

      // Back-to-back: start accepted in the done cycle
      issue(16'h0001, 16'h0002);
      chk("b2b_hold_flags", {equal, bigger, less, nib_used}, {3'b010, 3'd2});
      chk("b2b_busy", busy, 1);
      wait_done("b2b", 0, lat);
      chk_result("b2b", lat, 4, 1'b0, 1'b0, 1'b1, 4);
      @(negedge clk);

      // Second nibble differs, A smaller
      issue(16'h5300, 16'h5400);
      wait_done("nib2", 0, lat);
      chk_result("nib2", lat, 2, 1'b0, 1'b0, 1'b1, 2);
      @(negedge clk);

      // Reset mid-compare aborts without done
      issue(16'h1234, 16'h1235);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("midreset_outputs", {busy, done, equal, bigger, less, nib_used}, '0);
      n = 0;
      repeat (8) begin
         @(negedge clk);
         if (done === 1'b1) n++;
      end
      chk("midreset_no_done", n, 0);

      chk_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL global_timeout bench did not finish, required completion");
      $fatal(1);
   end

endmodule

// File: doc/wide_cmp_seq.md
Name: wide_cmp_seq

Overview:
Sequential wide-word magnitude comparator built on the team's 4-bit `comparator` block.
- Accepts two NIBBLES*4-bit operands through a start/done handshake.
- Feeds one nibble pair per cycle, MSB nibble first, into one `comparator` instance (inputs A,B [3:0]; outputs equal, bigger, less).
- Consumes that instance's equal/bigger/less outputs and stops at the first unequal nibble.
- Sits directly downstream of the 4-bit comparator and extends it to arbitrary widths without replicating the gate network.

Parameters:
- NIBBLES, 4, number of 4-bit digits per operand (operand width W = 4*NIBBLES); legal range 1..16.
- CW, $clog2(NIBBLES+1), width of the nibble-count output (derived; not overridden).

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a compare; accepted only when not busy.
- a  input  W  operand A, sampled on accepted start.
- b  input  W  operand B, sampled on accepted start.
- busy  output  1  high while a compare is in progress.
- done  output  1  one-cycle pulse; result flags valid from this cycle on.
- equal  output  1  A == B (last completed compare).
- bigger  output  1  A > B (last completed compare).
- less  output  1  A < B (last completed compare).
- nib_used  output  CW  nibbles examined by last compare (1..NIBBLES).

Behaviour:
- Reset (rst high at a clock edge):
  - State goes to IDLE.
  - busy, done, equal, bigger, less = 0; nib_used = 0; internal operand and index registers = 0.
  - Reset wins over every other input in the same cycle, including mid-compare; an aborted compare produces no done.
- States: IDLE, SCAN.
- IDLE:
  - start=1 at edge: latch a/b into op_a/op_b, set idx = NIBBLES-1, go to SCAN, busy=1.
  - start=0: stay in IDLE.
- SCAN:
  - Comparator inputs are op_a[4*idx+3:4*idx] and op_b[4*idx+3:4*idx]. The comparator is combinational; its result is used in the same cycle.
  - Nibble bigger or less: go to IDLE. Register equal=0 and bigger/less = comparator values. nib_used = NIBBLES-idx. done=1 for the next cycle; busy=0.
  - Nibble equal and idx==0: go to IDLE. Register equal=1, bigger=0, less=0, nib_used=NIBBLES, done=1; busy=0.
  - Nibble equal and idx>0: decrement idx; stay in SCAN.
- Latency: start accepted at edge T gives done high during cycle T+k, where k = index of first differing nibble counted from MSB (1..NIBBLES), or k = NIBBLES if the operands are equal.
  - busy is high for exactly k cycles; no bubble cycles.
- start while busy is ignored; the operands are not resampled. Latched operands keep the compare immune to a/b changes mid-scan.
- start in the done cycle (state IDLE) is accepted: back-to-back throughput is one compare per k+1 cycles.
- Result flags and nib_used change only on a completing edge and otherwise hold.
  - After reset all flags are 0; after any done exactly one flag is 1 (one-hot).
- done is a single-cycle pulse, never high for two consecutive cycles.
- NIBBLES=1: every compare takes one SCAN cycle; nib_used is always 1.

Decomposition:
- Shared package wide_cmp_pkg:
  - state encoding localparams ST_IDLE=1'b0, ST_SCAN=1'b1.
  - NIBBLE_W=4.
- Sub-module: the existing `comparator` module, instantiated once as the nibble comparator. No other sub-modules.
- Nibble select is an indexed part-select mux in the top.

Test Plan:
- Reset mid-operation: start a=16'h1234, b=16'h1235, assert rst in cycle 2 -> next cycle busy=0, done=0, all flags 0, nib_used=0; no done follows.
- MSB differs: a=16'h9000, b=16'h1FFF, start -> done one cycle later, bigger=1, equal=0, less=0, nib_used=1, busy high 1 cycle.
- LSB differs: a=16'h1234, b=16'h1235 -> done 4 cycles after start, less=1, nib_used=4.
- Equal operands: a=b=16'hABCD -> done at +4, equal=1, nib_used=4. Then a=b=16'h0000 -> same result.
- Busy/stability: start a=16'h0F00, b=16'h0E00, pulse start again and change a/b to 16'hFFFF/16'h0000 while busy -> ignored; done at +2 with bigger=1, nib_used=2.
- Back-to-back: assert start in the done cycle with a=16'h0001, b=16'h0002 -> accepted, second done 4 cycles later with less=1. done never high two consecutive cycles. Flags hold between dones.
